uart_bus_scheduler: RTL and testbench
=====================================

Name: uart_bus_scheduler

Overview:
Bus-master sequencer in front of the UART core's register bus (4-bit address, active-low chip-select/read/write strobes, 8-bit data). It shares the UART transmit path between two byte-stream requesters (A and B) using round-robin arbitration, and polls the status register before every transmit write. It also drains the receive FIFO into a one-entry holding register whenever the core's interrupt line is high.

Parameters:
ADDR_TXDATA, 4'h0, register address of the TX data write port
ADDR_RXDATA, 4'h1, register address of the RX data read port
ADDR_STATUS, 4'h2, register address of the status register
STAT_RXEMPTY_BIT, 0, status bit position; 1 = RX FIFO empty
STAT_TXFULL_BIT, 1, status bit position; 1 = TX FIFO full
STROBE_CYCLES, 2, width of the n_rd/n_we low phase in clocks (1..15)
BACKOFF_CYCLES, 16, idle clocks after a status read that shows TX full (1..255)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
a_valid_i  in  1  requester A has a TX byte
a_data_i  in  8  requester A byte; held stable while a_valid_i=1
a_ready_o  out  1  1-cycle pulse: A's byte written to the core
b_valid_i  in  1  requester B has a TX byte
b_data_i  in  8  requester B byte
b_ready_o  out  1  1-cycle pulse: B's byte written
rx_data_o  out  8  drained RX byte
rx_valid_o  out  1  holding register full
rx_ready_i  in  1  consumer takes the byte when rx_valid_o & rx_ready_i
AddrBus_o  out  4  core address
n_ChipSelect_o  out  1  core chip-select, active-low
n_rd_o  out  1  core read strobe, active-low
n_we_o  out  1  core write strobe, active-low
DataBus_o  out  8  write data to the core
DataBus_i  in  8  read data from the core
p_IrqSig_i  in  1  core interrupt
busy_o  out  1  FSM not in IDLE
stall_cnt_o  out  16  saturating count of TX-full status results

Behaviour:
- Reset values:
  - n_ChipSelect_o, n_rd_o and n_we_o are 1.
  - AddrBus_o and DataBus_o are 0.
  - a_ready_o, b_ready_o, rx_valid_o and busy_o are 0.
  - rx_data_o is 0 and stall_cnt_o is 0.
  - The round-robin pointer is reset to "A next".
  - State is IDLE.
- Reset mid-access: strobes and chip-select return to 1 immediately, because the reset is asynchronous. No ready pulse is issued and the holding register is cleared.
- Bus access (shared by every read and write) runs in three phases:
  - SETUP, 1 cycle: AddrBus_o valid, n_ChipSelect_o=0, DataBus_o valid for writes.
  - STROBE, STROBE_CYCLES cycles: n_rd_o or n_we_o = 0.
  - HOLD, 1 cycle: strobe=1, chip-select still 0.
  - DataBus_i is sampled on the edge that ends the last STROBE cycle.
  - Address, data and chip-select are constant from SETUP through HOLD.
  - Chip-select goes back to 1 in the cycle after HOLD.
  - Never more than one strobe is low at a time.
- FSM states: IDLE, STAT, DECIDE, TXWR, RXRD, BACKOFF.
- IDLE leaves when need_rx or need_tx is true, and moves to STAT:
  - need_rx = p_IrqSig_i & ~rx_valid_o
  - need_tx = a_valid_i | b_valid_i
- STAT: read ADDR_STATUS and latch the result into stat_q, then go to DECIDE.
- DECIDE, 1 cycle, priority order:
  1. need_rx & ~stat_q[RXEMPTY] -> RXRD.
  2. Else need_tx & ~stat_q[TXFULL] -> TXWR. The grantee is chosen by round-robin (the pointer-preferred requester if it is valid, otherwise the other one) and is latched.
  3. Else need_tx & stat_q[TXFULL] -> stall_cnt_o +1, saturating at 16'hFFFF, then BACKOFF.
  4. Else -> IDLE.
- TXWR:
  - Write the grantee's data to ADDR_TXDATA.
  - Pulse the grantee's ready during HOLD.
  - Move the pointer to the other requester.
  - Return to IDLE. Every byte gets a fresh status poll.
- RXRD:
  - Read ADDR_RXDATA.
  - In HOLD, load rx_data_o and set rx_valid_o.
  - Return to IDLE.
- BACKOFF: count BACKOFF_CYCLES clocks, then IDLE.
- Holding register:
  - rx_valid_o clears on rx_valid_o & rx_ready_i.
  - A load and a consume never coincide, because a load requires ~rx_valid_o at DECIDE.
  - While rx_valid_o=1, no RX reads are issued and TX continues.
- Grants:
  - A requester dropping valid after grant is illegal; its data is still written.
  - At most one ready pulse per access; a_ready_o and b_ready_o are never high together.
- Throughput: a TX byte costs (STROBE_CYCLES+2)*2+1 clocks = 9 at the default, plus the return through IDLE.

Decomposition:
- Package uart_sched_pkg: the state enum, default register addresses and default status bit positions.
- Sub-module uart_bus_access: the SETUP/STROBE/HOLD sequencer.
  - Inputs: start, rnw, addr, wdata.
  - Outputs: rdata, hold_pulse, done.
  - Instantiated once; the scheduler FSM drives it.

Test Plan:
- Only A valid (0x55), status=0x01 (TX not full, RX empty) -> status read at addr 2, then write of 0x55 to addr 0 with n_we_o low for exactly 2 cycles; a_ready_o pulses once, in HOLD.
- A and B both valid continuously, 4 bytes each, status never full -> writes alternate A,B,A,B…, starting with A after reset; no ready overlap.
- Status returns 0x02 (TX full) 3 times, then 0x01 -> stall_cnt_o=3, 16 idle clocks between polls, then the write completes.
- p_IrqSig_i=1, status=0x00, RX data 0xA7, A also valid -> RX read happens before the TX write; rx_data_o=0xA7, rx_valid_o=1. With rx_ready_i held 0, no further addr-1 reads occur while TX writes continue.
- rst asserted during the STROBE phase of a write -> n_we_o and n_ChipSelect_o are 1 immediately, no ready pulse, state IDLE, stall_cnt_o=0.

Source files
------------

// File: rtl/uart_sched_pkg.sv
// Shared types and default register map for the UART bus scheduler.
package uart_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        STAT,
        DECIDE,
        TXWR,
        RXRD,
        BACKOFF
    } schedState_t;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_SETUP,
        PH_STROBE,
        PH_HOLD
    } busPhase_t;

    localparam logic [3:0]  DEF_ADDR_TXDATA      = 4'h0;
    localparam logic [3:0]  DEF_ADDR_RXDATA      = 4'h1;
    localparam logic [3:0]  DEF_ADDR_STATUS      = 4'h2;
    localparam int unsigned DEF_STAT_RXEMPTY_BIT = 0;
    localparam int unsigned DEF_STAT_TXFULL_BIT  = 1;

endpackage

// File: rtl/uart_bus_access.sv
// SETUP / STROBE / HOLD sequencer for one UART core register access.
module uart_bus_access
    import uart_sched_pkg::*;
#(
    parameter int unsigned STROBE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rnw,
    input  logic [3:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       hold_pulse,
    output logic       done,
    output logic [3:0] AddrBus_o,
    output logic       n_ChipSelect_o,
    output logic       n_rd_o,
    output logic       n_we_o,
    output logic [7:0] DataBus_o,
    input  logic [7:0] DataBus_i
);

    localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES - 1);

    busPhase_t  phase, phaseNext;
    logic [3:0] strobeCnt;
    logic       rnwQ;

    always_comb begin
        phaseNext = phase;
        case (phase)
            PH_IDLE:   if (start) phaseNext = PH_SETUP;
            PH_SETUP:  phaseNext = PH_STROBE;
            PH_STROBE: if (strobeCnt == STROBE_LAST) phaseNext = PH_HOLD;
            PH_HOLD:   phaseNext = PH_IDLE;
            default:   phaseNext = PH_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase     <= PH_IDLE;
            strobeCnt <= '0;
            rnwQ      <= 1'b1;
            AddrBus_o <= '0;
            DataBus_o <= '0;
            rdata     <= '0;
        end else begin
            phase <= phaseNext;
            if (phase == PH_IDLE && start) begin
                AddrBus_o <= addr;
                DataBus_o <= wdata;
                rnwQ      <= rnw;
            end
            if (phase == PH_SETUP)
                strobeCnt <= '0;
            else if (phase == PH_STROBE)
                strobeCnt <= strobeCnt + 4'd1;
            // Read data is captured on the edge that closes the last strobe cycle.
            if (phase == PH_STROBE && strobeCnt == STROBE_LAST && rnwQ)
                rdata <= DataBus_i;
        end
    end

    // Strobes decode straight from the async-reset phase so reset releases them at once.
    assign n_ChipSelect_o = (phase == PH_IDLE);
    assign n_rd_o         = !(phase == PH_STROBE && rnwQ);
    assign n_we_o         = !(phase == PH_STROBE && !rnwQ);
    assign hold_pulse     = (phase == PH_HOLD);
    assign done           = hold_pulse;

endmodule

// File: rtl/uart_bus_scheduler.sv
// Round-robin TX arbiter and RX drainer driving the UART core register bus.
module uart_bus_scheduler
    import uart_sched_pkg::*;
#(
    parameter logic [3:0]  ADDR_TXDATA      = DEF_ADDR_TXDATA,
    parameter logic [3:0]  ADDR_RXDATA      = DEF_ADDR_RXDATA,
    parameter logic [3:0]  ADDR_STATUS      = DEF_ADDR_STATUS,
    parameter int unsigned STAT_RXEMPTY_BIT = DEF_STAT_RXEMPTY_BIT,
    parameter int unsigned STAT_TXFULL_BIT  = DEF_STAT_TXFULL_BIT,
    parameter int unsigned STROBE_CYCLES    = 2,
    parameter int unsigned BACKOFF_CYCLES   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid_i,
    input  logic [7:0]  a_data_i,
    output logic        a_ready_o,
    input  logic        b_valid_i,
    input  logic [7:0]  b_data_i,
    output logic        b_ready_o,
    output logic [7:0]  rx_data_o,
    output logic        rx_valid_o,
    input  logic        rx_ready_i,
    output logic [3:0]  AddrBus_o,
    output logic        n_ChipSelect_o,
    output logic        n_rd_o,
    output logic        n_we_o,
    output logic [7:0]  DataBus_o,
    input  logic [7:0]  DataBus_i,
    input  logic        p_IrqSig_i,
    output logic        busy_o,
    output logic [15:0] stall_cnt_o
);

    localparam logic [7:0] BACKOFF_LAST = 8'(BACKOFF_CYCLES - 1);

    schedState_t state, stateNext;
    logic        statRxEmptyQ, statTxFullQ;
    logic        ptrB, grantB, grantBQ;
    logic [7:0]  backoffCnt;
    logic        needRx, needTx;
    logic        start, rnw;
    logic [3:0]  accAddr;
    logic [7:0]  accWdata, rdata;
    logic        holdPulse, done;

    assign needRx = p_IrqSig_i & ~rx_valid_o;
    assign needTx = a_valid_i | b_valid_i;
    // Preferred requester wins if valid, otherwise the other one.
    assign grantB = ptrB ? b_valid_i : ~a_valid_i;

    always_comb begin
        stateNext = state;
        start     = 1'b0;
        rnw       = 1'b1;
        accAddr   = ADDR_STATUS;
        accWdata  = '0;
        case (state)
            IDLE: if (needRx || needTx) begin
                start     = 1'b1;
                stateNext = STAT;
            end
            STAT: if (done) stateNext = DECIDE;
            DECIDE: begin
                if (needRx && !statRxEmptyQ) begin
                    start     = 1'b1;
                    accAddr   = ADDR_RXDATA;
                    stateNext = RXRD;
                end else if (needTx && !statTxFullQ) begin
                    start     = 1'b1;
                    rnw       = 1'b0;
                    accAddr   = ADDR_TXDATA;
                    accWdata  = grantB ? b_data_i : a_data_i;
                    stateNext = TXWR;
                end else if (needTx) begin
                    stateNext = BACKOFF;
                end else begin
                    stateNext = IDLE;
                end
            end
            TXWR, RXRD: if (done) stateNext = IDLE;
            BACKOFF: if (backoffCnt == BACKOFF_LAST) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            statRxEmptyQ <= 1'b0;
            statTxFullQ  <= 1'b0;
            ptrB         <= 1'b0;
            grantBQ      <= 1'b0;
            backoffCnt   <= '0;
            stall_cnt_o  <= '0;
            rx_data_o    <= '0;
            rx_valid_o   <= 1'b0;
        end else begin
            state <= stateNext;
            if (state == STAT && done) begin
                statRxEmptyQ <= rdata[STAT_RXEMPTY_BIT];
                statTxFullQ  <= rdata[STAT_TXFULL_BIT];
            end
            if (state == DECIDE) begin
                grantBQ    <= grantB;
                backoffCnt <= '0;
                if (stateNext == BACKOFF && stall_cnt_o != '1)
                    stall_cnt_o <= stall_cnt_o + 16'd1;
            end
            if (state == BACKOFF)
                backoffCnt <= backoffCnt + 8'd1;
            if (state == TXWR && done)
                ptrB <= ~grantBQ;
            if (state == RXRD && done) begin
                rx_data_o  <= rdata;
                rx_valid_o <= 1'b1;
            end else if (rx_valid_o && rx_ready_i) begin
                rx_valid_o <= 1'b0;
            end
        end
    end

    assign a_ready_o = (state == TXWR) && holdPulse && !grantBQ;
    assign b_ready_o = (state == TXWR) && holdPulse && grantBQ;
    assign busy_o    = (state != IDLE);

    uart_bus_access #(
        .STROBE_CYCLES(STROBE_CYCLES)
    ) uBusAccess (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .rnw           (rnw),
        .addr          (accAddr),
        .wdata         (accWdata),
        .rdata         (rdata),
        .hold_pulse    (holdPulse),
        .done          (done),
        .AddrBus_o     (AddrBus_o),
        .n_ChipSelect_o(n_ChipSelect_o),
        .n_rd_o        (n_rd_o),
        .n_we_o        (n_we_o),
        .DataBus_o     (DataBus_o),
        .DataBus_i     (DataBus_i)
    );

endmodule

// File: tb/tb_uart_bus_scheduler.sv
// Directed bench for uart_bus_scheduler with a behavioural UART core and bus monitor.
module tb_uart_bus_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid_i, b_valid_i, rx_ready_i, p_IrqSig_i;
    logic [7:0]  a_data_i, b_data_i;
    logic        a_ready_o, b_ready_o, rx_valid_o, busy_o;
    logic [7:0]  rx_data_o, DataBus_o, DataBus_i;
    logic [3:0]  AddrBus_o;
    logic        n_ChipSelect_o, n_rd_o, n_we_o;
    logic [15:0] stall_cnt_o;

    int vectors = 0;
    int misses  = 0;

    always #5 clk = ~clk;

    uart_bus_scheduler #(
        .STROBE_CYCLES (2),
        .BACKOFF_CYCLES(16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .a_valid_i     (a_valid_i),
        .a_data_i      (a_data_i),
        .a_ready_o     (a_ready_o),
        .b_valid_i     (b_valid_i),
        .b_data_i      (b_data_i),
        .b_ready_o     (b_ready_o),
        .rx_data_o     (rx_data_o),
        .rx_valid_o    (rx_valid_o),
        .rx_ready_i    (rx_ready_i),
        .AddrBus_o     (AddrBus_o),
        .n_ChipSelect_o(n_ChipSelect_o),
        .n_rd_o        (n_rd_o),
        .n_we_o        (n_we_o),
        .DataBus_o     (DataBus_o),
        .DataBus_i     (DataBus_i),
        .p_IrqSig_i    (p_IrqSig_i),
        .busy_o        (busy_o),
        .stall_cnt_o   (stall_cnt_o)
    );

    // Core model: status register replays statusSeq, one entry per status read.
    logic [7:0] statusSeq [0:7];
    int         statLen = 1;
    logic [2:0] statIdx;
    logic [7:0] rxByte = 8'h00;

    assign DataBus_i = (AddrBus_o == 4'h2) ? statusSeq[statIdx] :
                       (AddrBus_o == 4'h1) ? rxByte : 8'h00;

    logic [3:0] accAddr [$];
    bit         accWr   [$];
    logic [7:0] accData [$];
    int         accStrb [$];
    int         gapLog  [$];
    bit         readyLog[$];
    int         protoErrs = 0;
    bit         inAcc, isWr, prevWeLow;
    logic [3:0] curAddr;
    logic [7:0] curData;
    int         strobes, gap;

    always @(negedge clk) begin
        if (rst) begin
            accAddr.delete(); accWr.delete(); accData.delete();
            accStrb.delete(); gapLog.delete(); readyLog.delete();
            statIdx = '0; inAcc = 0; gap = 0; prevWeLow = 0;
        end else begin
            if (!n_rd_o && !n_we_o) protoErrs++;
            if (a_ready_o && b_ready_o) protoErrs++;
            if ((a_ready_o || b_ready_o) && (n_ChipSelect_o || !n_we_o || !prevWeLow)) protoErrs++;
            if (a_ready_o) readyLog.push_back(1'b0);
            if (b_ready_o) readyLog.push_back(1'b1);
            if (!n_ChipSelect_o) begin
                if (!inAcc) begin
                    inAcc = 1; isWr = 0; strobes = 0;
                    curAddr = AddrBus_o; curData = DataBus_o;
                    gapLog.push_back(gap);
                end else if (AddrBus_o !== curAddr || DataBus_o !== curData) begin
                    protoErrs++;
                end
                if (!n_we_o) begin strobes++; isWr = 1; end
                if (!n_rd_o) strobes++;
            end else begin
                if (inAcc) begin
                    accAddr.push_back(curAddr); accWr.push_back(isWr);
                    accData.push_back(curData); accStrb.push_back(strobes);
                    if (!isWr && curAddr == 4'h2 && int'(statIdx) < statLen - 1) statIdx = statIdx + 3'd1;
                    inAcc = 0; gap = 0;
                end
                gap++;
            end
            prevWeLow = !n_we_o;
        end
    end

    task automatic doReset;
        rst = 1'b1;
        a_valid_i = 0; b_valid_i = 0; p_IrqSig_i = 0; rx_ready_i = 0;
        a_data_i = '0; b_data_i = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        doReset();
        vectors++;
        if ({n_ChipSelect_o, n_rd_o, n_we_o} !== 3'b111) begin
            misses++; $display("FAIL reset_strobes got %b want 111", {n_ChipSelect_o, n_rd_o, n_we_o});
        end
        vectors++;
        if ({AddrBus_o, DataBus_o} !== 12'h000) begin
            misses++; $display("FAIL reset_bus got %h want 000", {AddrBus_o, DataBus_o});
        end
        vectors++;
        if ({a_ready_o, b_ready_o, rx_valid_o, busy_o} !== 4'b0000) begin
            misses++; $display("FAIL reset_flags got %b want 0000", {a_ready_o, b_ready_o, rx_valid_o, busy_o});
        end
        vectors++;
        if ({rx_data_o, stall_cnt_o} !== 24'h0) begin
            misses++; $display("FAIL reset_regs got %h want 000000", {rx_data_o, stall_cnt_o});
        end
    endtask

    task automatic test_single_a;
        bit got = 0;
        statusSeq[0] = 8'h01; statLen = 1;
        doReset();
        a_data_i = 8'h55; a_valid_i = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (a_ready_o) begin a_valid_i = 0; got = 1; break; end
        end
        repeat (5) @(negedge clk);
        vectors++;
        if (!got) begin misses++; $display("FAIL single_timeout got no a_ready want pulse"); end
        vectors++;
        if (accAddr.size() !== 2) begin
            misses++; $display("FAIL single_acc_count got %0d want 2", accAddr.size());
        end else begin
            vectors++;
            if ({accAddr[0], accWr[0], accStrb[0]} !== {4'h2, 1'b0, 32'd2}) begin
                misses++; $display("FAIL single_stat_read got addr %h wr %b strb %0d want 2 0 2", accAddr[0], accWr[0], accStrb[0]);
            end
            vectors++;
            if ({accAddr[1], accWr[1], accData[1], accStrb[1]} !== {4'h0, 1'b1, 8'h55, 32'd2}) begin
                misses++; $display("FAIL single_tx_write got addr %h wr %b data %h strb %0d want 0 1 55 2", accAddr[1], accWr[1], accData[1], accStrb[1]);
            end
            vectors++;
            if (gapLog[1] !== 1) begin misses++; $display("FAIL single_decide_gap got %0d want 1", gapLog[1]); end
        end
        vectors++;
        if (readyLog.size() !== 1 || readyLog[0] !== 1'b0) begin
            misses++; $display("FAIL single_ready got %0d pulses want 1 from A", readyLog.size());
        end
        vectors++;
        if (busy_o !== 1'b0) begin misses++; $display("FAIL single_busy got %b want 0", busy_o); end
    endtask

    task automatic test_back_to_back;
        int aN = 0, bN = 0, wi = 0, badGaps = 0;
        logic [7:0] expOrder [0:7];
        expOrder[0] = 8'hA0; expOrder[1] = 8'hB0; expOrder[2] = 8'hA1; expOrder[3] = 8'hB1;
        expOrder[4] = 8'hA2; expOrder[5] = 8'hB2; expOrder[6] = 8'hA3; expOrder[7] = 8'hB3;
        statusSeq[0] = 8'h01; statLen = 1;
        doReset();
        a_data_i = 8'hA0; b_data_i = 8'hB0; a_valid_i = 1; b_valid_i = 1;
        for (int i = 0; i < 400 && (aN < 4 || bN < 4); i++) begin
            @(negedge clk);
            if (a_ready_o) begin aN++; if (aN == 4) a_valid_i = 0; else a_data_i = 8'hA0 + 8'(aN); end
            if (b_ready_o) begin bN++; if (bN == 4) b_valid_i = 0; else b_data_i = 8'hB0 + 8'(bN); end
        end
        repeat (5) @(negedge clk);
        vectors++;
        if (aN != 4 || bN != 4) begin misses++; $display("FAIL rr_timeout got A %0d B %0d want 4 4", aN, bN); end
        for (int i = 0; i < accAddr.size(); i++) begin
            if (i > 0 && gapLog[i] !== 1) badGaps++;
            if (accWr[i]) begin
                vectors++;
                if (wi > 7 || accData[i] !== expOrder[wi]) begin
                    misses++; $display("FAIL rr_write%0d got %h want %h", wi, accData[i], expOrder[wi & 7]);
                end
                wi++;
            end
        end
        vectors++;
        if (wi !== 8) begin misses++; $display("FAIL rr_write_count got %0d want 8", wi); end
        vectors++;
        if (badGaps !== 0) begin misses++; $display("FAIL rr_gaps got %0d non-unit gaps want 0", badGaps); end
        vectors++;
        if (readyLog.size() !== 8) begin misses++; $display("FAIL rr_ready_count got %0d want 8", readyLog.size()); end
    endtask

    task automatic test_backoff;
        bit got = 0;
        statusSeq[0] = 8'h02; statusSeq[1] = 8'h02; statusSeq[2] = 8'h02; statusSeq[3] = 8'h01;
        statLen = 4;
        doReset();
        a_data_i = 8'h3C; a_valid_i = 1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (a_ready_o) begin a_valid_i = 0; got = 1; break; end
        end
        repeat (5) @(negedge clk);
        vectors++;
        if (!got) begin misses++; $display("FAIL backoff_timeout got no a_ready want pulse"); end
        vectors++;
        if (stall_cnt_o !== 16'd3) begin misses++; $display("FAIL backoff_stall got %0d want 3", stall_cnt_o); end
        vectors++;
        if (accAddr.size() !== 5) begin
            misses++; $display("FAIL backoff_acc_count got %0d want 5", accAddr.size());
        end else begin
            // DECIDE + 16 BACKOFF + IDLE leaves chip-select high 18 clocks between polls.
            for (int i = 1; i < 4; i++) begin
                vectors++;
                if (gapLog[i] !== 18 || accAddr[i] !== 4'h2) begin
                    misses++; $display("FAIL backoff_gap%0d got %0d addr %h want 18 addr 2", i, gapLog[i], accAddr[i]);
                end
            end
            vectors++;
            if ({accWr[4], accData[4], gapLog[4]} !== {1'b1, 8'h3C, 32'd1}) begin
                misses++; $display("FAIL backoff_write got wr %b data %h gap %0d want 1 3c 1", accWr[4], accData[4], gapLog[4]);
            end
        end
    endtask

    task automatic test_rx_priority;
        int aN = 0, rxReads = 0, writes = 0;
        statusSeq[0] = 8'h00; statLen = 1; rxByte = 8'hA7;
        doReset();
        p_IrqSig_i = 1; a_data_i = 8'h11; a_valid_i = 1;
        for (int i = 0; i < 300 && aN < 3; i++) begin
            @(negedge clk);
            if (a_ready_o) begin aN++; if (aN == 3) a_valid_i = 0; end
        end
        repeat (5) @(negedge clk);
        for (int i = 0; i < accAddr.size(); i++) begin
            if (!accWr[i] && accAddr[i] == 4'h1) rxReads++;
            if (accWr[i]) writes++;
        end
        vectors++;
        if (accAddr.size() < 4) begin
            misses++; $display("FAIL rx_acc_count got %0d want 8", accAddr.size());
        end else if ({accAddr[1], accWr[1], accAddr[3], accWr[3], accData[3]} !== {4'h1, 1'b0, 4'h0, 1'b1, 8'h11}) begin
            misses++; $display("FAIL rx_order got %h%b %h%b %h want 10 01 11", accAddr[1], accWr[1], accAddr[3], accWr[3], accData[3]);
        end
        vectors++;
        if (rxReads !== 1 || writes !== 3) begin
            misses++; $display("FAIL rx_counts got rx %0d tx %0d want 1 3", rxReads, writes);
        end
        vectors++;
        if ({rx_valid_o, rx_data_o} !== {1'b1, 8'hA7}) begin
            misses++; $display("FAIL rx_hold got %b %h want 1 a7", rx_valid_o, rx_data_o);
        end
        p_IrqSig_i = 0; rx_ready_i = 1;
        @(negedge clk);
        rx_ready_i = 0;
        vectors++;
        if (rx_valid_o !== 1'b0) begin misses++; $display("FAIL rx_consume got %b want 0", rx_valid_o); end
    endtask

    task automatic test_reset_mid;
        bit got = 0;
        int pulses = 0;
        statusSeq[0] = 8'h00; statLen = 1; rxByte = 8'h5A;
        doReset();
        p_IrqSig_i = 1; a_data_i = 8'h77; a_valid_i = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (a_ready_o) pulses++;
            if (!n_we_o) begin got = 1; break; end
        end
        vectors++;
        if (!got || rx_valid_o !== 1'b1) begin
            misses++; $display("FAIL midrst_setup got strobe %b rx_valid %b want 1 1", got, rx_valid_o);
        end
        #1 rst = 1'b1;
        #1;
        vectors++;
        if ({n_we_o, n_ChipSelect_o, n_rd_o} !== 3'b111) begin
            misses++; $display("FAIL midrst_strobes got %b want 111", {n_we_o, n_ChipSelect_o, n_rd_o});
        end
        vectors++;
        if ({busy_o, a_ready_o, rx_valid_o, stall_cnt_o} !== 19'h0) begin
            misses++; $display("FAIL midrst_state got busy %b rdy %b rxv %b stall %0d want 0 0 0 0", busy_o, a_ready_o, rx_valid_o, stall_cnt_o);
        end
        a_valid_i = 0; p_IrqSig_i = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (a_ready_o || busy_o) pulses++;
        end
        vectors++;
        if (pulses !== 0) begin misses++; $display("FAIL midrst_no_ready got %0d events want 0", pulses); end
    endtask

    task automatic test_protocol;
        vectors++;
        if (protoErrs !== 0) begin misses++; $display("FAIL bus_protocol got %0d violations want 0", protoErrs); end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) statusSeq[i] = 8'h01;
        test_reset();
        test_single_a();
        test_back_to_back();
        test_backoff();
        test_rx_priority();
        test_reset_mid();
        test_protocol();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule
